// File: rtl/ft245_pkg.sv
// Shared FT245 definitions: uploader state encoding, byte-select encoding and
// default write-strobe timing for the FT245 asynchronous FIFO interface.
package ft245_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_TXE,
    ST_SETUP,
    ST_STROBE,
    ST_GAP,
    ST_DONE
  } upl_state_e;

  typedef enum logic [1:0] {
    SEL_HDR0,
    SEL_HDR1,
    SEL_LO,
    SEL_HI
  } byte_sel_e;

  localparam logic [15:0] DEFAULT_SYNC_WORD       = 16'hA55A;
  localparam int          DEFAULT_WR_PULSE_CYCLES = 3;
  localparam int          DEFAULT_WR_GAP_CYCLES   = 2;
  localparam int          TIMER_WIDTH             = 8;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with a configurable reset value.
module sync_2ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RESET_VALUE;
      r_sync <= RESET_VALUE;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/adc_ram_ft245_uploader.sv
// Streams a finished ADC capture from RAM port B to the FT245 write FIFO:
// optional 2-byte sync header, then every 16-bit sample low byte first.
module adc_ram_ft245_uploader
  import ft245_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 10,
  parameter logic [ADDR_WIDTH-1:0] SAMPLING_NUM    = 10'd1023,
  parameter bit                    SEND_HEADER     = 1'b1,
  parameter logic [15:0]           SYNC_WORD       = DEFAULT_SYNC_WORD,
  parameter int                    WR_PULSE_CYCLES = DEFAULT_WR_PULSE_CYCLES,
  parameter int                    WR_GAP_CYCLES   = DEFAULT_WR_GAP_CYCLES
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  output logic [ADDR_WIDTH-1:0] RAM_RD_ADDR,
  input  logic [15:0]           RAM_DATA_IN,
  input  logic                  FT_TXE_N,
  output logic                  FT_WR,
  output logic [7:0]            FT_DATA,
  output logic                  FT_DATA_OE,
  output logic                  BUSY,
  output logic                  UPLOAD_DONE
);

  localparam logic [TIMER_WIDTH-1:0] PULSE_LAST = TIMER_WIDTH'(WR_PULSE_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] GAP_LAST   = TIMER_WIDTH'(WR_GAP_CYCLES - 1);

  upl_state_e              r_state, w_state_next;
  byte_sel_e               r_sel, w_sel_next;
  logic [TIMER_WIDTH-1:0]  r_cnt, w_cnt_next;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr_next;
  logic [15:0]             r_word, w_word_next;
  logic                    r_wr, w_wr_next;
  logic [7:0]              r_data, w_data_next;
  logic                    r_oe, w_oe_next;
  logic                    r_busy, w_busy_next;
  logic                    r_done, w_done_next;
  logic                    w_txe_s;
  logic [7:0]              w_sel_byte;

  // Until the synchronizer has seen the pin, treat the FIFO as full.
  sync_2ff #(
    .WIDTH       (1),
    .RESET_VALUE (1'b1)
  ) u_txe_sync (
    .i_clk (CLK),
    .i_rst (RST),
    .i_d   (FT_TXE_N),
    .o_q   (w_txe_s)
  );

  always_comb begin
    case (r_sel)
      SEL_HDR0: w_sel_byte = SYNC_WORD[7:0];
      SEL_HDR1: w_sel_byte = SYNC_WORD[15:8];
      SEL_LO:   w_sel_byte = r_word[7:0];
      default:  w_sel_byte = r_word[15:8];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_sel   <= SEL_HDR0;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_word  <= '0;
      r_wr    <= 1'b0;
      r_data  <= 8'h00;
      r_oe    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
      r_cnt   <= w_cnt_next;
      r_addr  <= w_addr_next;
      r_word  <= w_word_next;
      r_wr    <= w_wr_next;
      r_data  <= w_data_next;
      r_oe    <= w_oe_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  // Outputs are registered, so each branch sets the values for the state being entered.
  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_cnt_next   = r_cnt;
    w_addr_next  = r_addr;
    w_word_next  = r_word;
    w_wr_next    = 1'b0;
    w_data_next  = r_data;
    w_oe_next    = r_oe;
    w_busy_next  = r_busy;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (START) begin
          w_addr_next = '0;
          w_cnt_next  = '0;
          w_busy_next = 1'b1;
          if (SEND_HEADER) begin
            w_state_next = ST_WAIT_TXE;
            w_sel_next   = SEL_HDR0;
          end else begin
            w_state_next = ST_FETCH;
            w_sel_next   = SEL_LO;
          end
        end
      end
      ST_FETCH: begin
        if (r_cnt == '0) begin
          w_cnt_next = r_cnt + 1'b1;
        end else begin
          w_cnt_next   = '0;
          w_word_next  = RAM_DATA_IN;
          w_sel_next   = SEL_LO;
          w_state_next = ST_WAIT_TXE;
        end
      end
      ST_WAIT_TXE: begin
        if (!w_txe_s) begin
          w_state_next = ST_SETUP;
          w_data_next  = w_sel_byte;
          w_oe_next    = 1'b1;
        end
      end
      ST_SETUP: begin
        w_state_next = ST_STROBE;
        w_cnt_next   = '0;
        w_wr_next    = 1'b1;
      end
      ST_STROBE: begin
        if (r_cnt == PULSE_LAST) begin
          w_state_next = ST_GAP;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
          w_wr_next  = 1'b1;
        end
      end
      ST_GAP: begin
        if (r_cnt != GAP_LAST) begin
          w_cnt_next = r_cnt + 1'b1;
        end else begin
          w_cnt_next = '0;
          case (r_sel)
            SEL_HDR0: begin
              w_sel_next   = SEL_HDR1;
              w_state_next = ST_WAIT_TXE;
            end
            SEL_HDR1: begin
              w_sel_next   = SEL_LO;
              w_state_next = ST_FETCH;
            end
            SEL_LO: begin
              w_sel_next   = SEL_HI;
              w_state_next = ST_WAIT_TXE;
            end
            default: begin
              // Compare, never wrap: the last address ends the run.
              if (r_addr == SAMPLING_NUM) begin
                w_state_next = ST_DONE;
                w_done_next  = 1'b1;
                w_oe_next    = 1'b0;
                w_busy_next  = 1'b0;
              end else begin
                w_addr_next  = r_addr + 1'b1;
                w_sel_next   = SEL_LO;
                w_state_next = ST_FETCH;
              end
            end
          endcase
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign RAM_RD_ADDR = r_addr;
  assign FT_WR       = r_wr;
  assign FT_DATA     = r_data;
  assign FT_DATA_OE  = r_oe;
  assign BUSY        = r_busy;
  assign UPLOAD_DONE = r_done;

endmodule

// File: tb/tb_adc_ram_ft245_uploader.sv
// Scoreboard bench for the FT245 uploader: stimulus pushes expected bytes,
// a negedge monitor pops and checks each FT_WR strobe and its timing.
module tb_adc_ram_ft245_uploader;

  localparam int PULSE = 3;
  localparam int GAP   = 2;

  logic        clk;
  logic        rst;
  logic        start_a, start_b;
  logic        txe_n;
  logic [9:0]  addr_a, addr_b;
  logic [15:0] ram_q_a, ram_q_b;
  logic        wr_a, wr_b, oe_a, oe_b, busy_a, busy_b, done_a, done_b;
  logic [7:0]  data_a, data_b;

  logic [15:0] ram_a [0:1023];
  logic [15:0] ram_b [0:3];
  logic [7:0]  vec_b [0:7];

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_pulses = 0;
  int          n_done = 0;
  int          rise_cyc = 0;
  int          done_cyc = 0;
  int          busy_rise_cyc = 0;
  logic [7:0]  exp_q [$];
  logic        sel_b = 1'b0;
  logic        mon_hold = 1'b0;

  logic        m_wr, m_oe, m_busy, m_done;
  logic [7:0]  m_data;

  assign m_wr   = sel_b ? wr_b   : wr_a;
  assign m_oe   = sel_b ? oe_b   : oe_a;
  assign m_busy = sel_b ? busy_b : busy_a;
  assign m_done = sel_b ? done_b : done_a;
  assign m_data = sel_b ? data_b : data_a;

  adc_ram_ft245_uploader #(
    .ADDR_WIDTH(10), .SAMPLING_NUM(10'd1023), .SEND_HEADER(1'b1),
    .SYNC_WORD(16'hA55A), .WR_PULSE_CYCLES(PULSE), .WR_GAP_CYCLES(GAP)
  ) u_dut_a (
    .CLK(clk), .RST(rst), .START(start_a), .RAM_RD_ADDR(addr_a),
    .RAM_DATA_IN(ram_q_a), .FT_TXE_N(txe_n), .FT_WR(wr_a), .FT_DATA(data_a),
    .FT_DATA_OE(oe_a), .BUSY(busy_a), .UPLOAD_DONE(done_a)
  );

  adc_ram_ft245_uploader #(
    .ADDR_WIDTH(10), .SAMPLING_NUM(10'd3), .SEND_HEADER(1'b0),
    .SYNC_WORD(16'hA55A), .WR_PULSE_CYCLES(PULSE), .WR_GAP_CYCLES(GAP)
  ) u_dut_b (
    .CLK(clk), .RST(rst), .START(start_b), .RAM_RD_ADDR(addr_b),
    .RAM_DATA_IN(ram_q_b), .FT_TXE_N(txe_n), .FT_WR(wr_b), .FT_DATA(data_b),
    .FT_DATA_OE(oe_b), .BUSY(busy_b), .UPLOAD_DONE(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    ram_q_a <= ram_a[addr_a];
    ram_q_b <= ram_b[addr_b[1:0]];
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_pulses(input int target, input int budget, input string name);
    int t = 0;
    while (n_pulses < target && t < budget) begin
      tick();
      t++;
    end
    check(name, n_pulses, target);
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int t = 0;
    while (n_done < target && t < budget) begin
      tick();
      t++;
    end
    check(name, n_done, target);
  endtask

  task automatic push_a();
    logic [15:0] w;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hA5);
    for (int a = 0; a < 1024; a++) begin
      w = 16'(a);
      exp_q.push_back(w[7:0]);
      exp_q.push_back(w[15:8]);
    end
  endtask

  // Monitor: one byte per FT_WR rising edge, width and hold checked per byte.
  initial begin
    logic       prev_wr = 1'b0;
    logic       prev_busy = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] cur_byte = 8'h00;
    logic [7:0] e;
    int         width = 0;
    int         gap_left = 0;
    forever begin
      @(negedge clk);
      if (mon_hold) begin
        width = 0;
        gap_left = 0;
      end else begin
        if (m_busy && !prev_busy) busy_rise_cyc = cyc;
        if (m_done) begin
          n_done++;
          done_cyc = cyc;
        end
        if (m_wr && !prev_wr) begin
          n_pulses++;
          rise_cyc = cyc;
          width = 1;
          check("setup_stable", int'(m_data), int'(prev_data));
          check("oe_during_strobe", int'(m_oe), 1);
          if (exp_q.size() == 0) begin
            check("byte_unexpected", int'(m_data), -1);
          end else begin
            e = exp_q.pop_front();
            check("byte", int'(m_data), int'(e));
          end
          cur_byte = m_data;
        end else if (m_wr) begin
          width++;
          check("strobe_hold", int'(m_data), int'(cur_byte));
        end else if (prev_wr) begin
          check("wr_width", width, PULSE);
          check("gap_hold", int'(m_data), int'(cur_byte));
          gap_left = GAP - 1;
        end else if (gap_left > 0) begin
          gap_left--;
          check("gap_hold", int'(m_data), int'(cur_byte));
        end
      end
      prev_wr   = mon_hold ? 1'b0 : m_wr;
      prev_busy = m_busy;
      prev_data = m_data;
    end
  end

  initial begin
    int p0, d0, c, p1, wr_hi;
    for (int i = 0; i < 1024; i++) ram_a[i] = 16'(i);
    ram_b[0] = 16'h0ABC; ram_b[1] = 16'h0123; ram_b[2] = 16'h0FFF; ram_b[3] = 16'h0000;
    vec_b[0] = 8'hBC; vec_b[1] = 8'h0A; vec_b[2] = 8'h23; vec_b[3] = 8'h01;
    vec_b[4] = 8'hFF; vec_b[5] = 8'h0F; vec_b[6] = 8'h00; vec_b[7] = 8'h00;

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; txe_n = 1'b0;
    repeat (3) tick();
    check("rst_ft_wr", int'(wr_a), 0);
    check("rst_ft_data", int'(data_a), 0);
    check("rst_oe", int'(oe_a), 0);
    check("rst_addr", int'(addr_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_b_busy", int'(busy_b), 0);
    rst = 1'b0;
    repeat (4) tick();

    // Run 1: full default upload with TXE_N held low.
    push_a();
    p0 = n_pulses; d0 = n_done; c = cyc;
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_done(d0 + 1, 17000, "run1_done_seen");
    check("run1_pulses", n_pulses - p0, 2050);
    check("run1_busy_latency", busy_rise_cyc, c + 1);
    check("run1_done_cycle", done_cyc, c + 1 + 16398);
    check("run1_queue_empty", exp_q.size(), 0);
    tick();
    check("run1_done_one_cycle", int'(done_a), 0);
    check("run1_busy_clear", int'(busy_a), 0);
    check("run1_oe_clear", int'(oe_a), 0);

    // Run 2: TXE stall, TXE rising mid-strobe, ignored START re-pulse.
    push_a();
    p0 = n_pulses; d0 = n_done;
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_pulses(p0 + 2, 200, "stall_reach_byte2");
    repeat (3) tick();
    txe_n = 1'b1;
    wr_hi = 0;
    repeat (50) begin
      tick();
      if (wr_a) wr_hi++;
    end
    check("stall_wr_low", wr_hi, 0);
    check("stall_no_byte", n_pulses - p0, 2);
    c = cyc; txe_n = 1'b0;
    wait_pulses(p0 + 3, 20, "stall_resume_seen");
    check("stall_resume_cycle", rise_cyc, c + 4);

    wait_pulses(p0 + 10, 300, "strobe_txe_reach");
    txe_n = 1'b1;
    repeat (12) tick();
    check("strobe_txe_blocks_next", n_pulses - p0, 10);
    txe_n = 1'b0;

    wait_pulses(p0 + 500, 5000, "repulse_reach");
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_done(d0 + 1, 20000, "run2_done_seen");
    check("run2_pulses", n_pulses - p0, 2050);
    check("run2_queue_empty", exp_q.size(), 0);
    repeat (20) tick();
    check("run2_single_done", n_done - d0, 1);
    check("run2_no_restart", int'(busy_a), 0);

    // Run 3: reset in the middle of byte 100, no resumption afterwards.
    push_a();
    p0 = n_pulses;
    start_a = 1'b1; tick(); start_a = 1'b0;
    wait_pulses(p0 + 100, 2000, "rst_reach_byte100");
    mon_hold = 1'b1; rst = 1'b1;
    tick();
    check("midrst_ft_wr", int'(wr_a), 0);
    check("midrst_oe", int'(oe_a), 0);
    check("midrst_busy", int'(busy_a), 0);
    check("midrst_addr", int'(addr_a), 0);
    rst = 1'b0;
    repeat (2) tick();
    exp_q.delete();
    mon_hold = 1'b0;
    p1 = n_pulses;
    repeat (40) tick();
    check("midrst_no_resume", n_pulses, p1);
    check("midrst_idle", int'(busy_a), 0);

    // Run 4: headerless 4-word capture on the second instance.
    sel_b = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(vec_b[i]);
    p0 = n_pulses; d0 = n_done; c = cyc;
    start_b = 1'b1; tick(); start_b = 1'b0;
    wait_done(d0 + 1, 500, "b_done_seen");
    check("b_pulses", n_pulses - p0, 8);
    check("b_done_cycle", done_cyc, c + 1 + 64);
    check("b_queue_empty", exp_q.size(), 0);
    repeat (10) tick();
    check("b_single_done", n_done - d0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_ram_ft245_uploader.md
# adc_ram_ft245_uploader

Drains a completed ADC capture from the dual-port `ADC_RAM` (port B) and streams it to the host through the FT245 asynchronous write FIFO. It is started by the one-cycle capture-done pulse from the ADC capture block. It sends a 2-byte sync header, then every stored 16-bit sample (addresses 0..SAMPLING_NUM) as two bytes, little-endian. It ends with a one-cycle done pulse so the top level can re-arm the next capture.

## Interface
- `ADDR_WIDTH`, 10, RAM read address width.
- `SAMPLING_NUM`, 10'd1023, last RAM address sent (word count = SAMPLING_NUM+1).
- `SEND_HEADER`, 1, 1 = prepend sync header bytes.
- `SYNC_WORD`, 16'hA55A, header word, sent `[7:0]` then `[15:8]`.
- `WR_PULSE_CYCLES`, 3, CLK cycles `FT_WR` is held high per byte (≥1).
- `WR_GAP_CYCLES`, 2, CLK cycles after `FT_WR` falls: data held, `FT_TXE_N` ignored (≥1).
- `CLK` in 1: single clock; everything is synchronous to its rising edge.
- `RST` in 1: synchronous, active-high reset.
- `START` in 1: one-cycle pulse (capture done); ignored unless idle.
- `RAM_RD_ADDR` out ADDR_WIDTH: RAM port-B address; 1-cycle read latency.
- `RAM_DATA_IN` in 16: RAM port-B data.
- `FT_TXE_N` in 1: FT245 TX-FIFO-not-ready, asynchronous, active low.
- `FT_WR` out 1: FT245 write strobe; byte latched on falling edge.
- `FT_DATA` out 8: byte driven to the FT245 bus.
- `FT_DATA_OE` out 1: 1 = drive the top-level bidirectional bus.
- `BUSY` out 1: high from the cycle after START is accepted until the DONE state.
- `UPLOAD_DONE` out 1: one-cycle pulse after the last byte's gap.

## Operation
- `FT_TXE_N` passes through a 2-flop synchronizer (`txe_s`); reset value 1 (not ready).
- States:
  - IDLE: on START go to WAIT_TXE with the header byte if SEND_HEADER, otherwise to FETCH at address 0. Clear the address and byte counters.
  - FETCH (2 cycles): cycle 1 drives the address; cycle 2 latches `RAM_DATA_IN` into the word register and selects the low byte. Then go to WAIT_TXE.
  - WAIT_TXE: stay while `txe_s`=1. Go to SETUP when `txe_s`=0.
  - SETUP (1 cycle): `FT_DATA` = selected byte, `FT_DATA_OE`=1, `FT_WR`=0.
  - STROBE (WR_PULSE_CYCLES): `FT_WR`=1; data stable.
  - GAP (WR_GAP_CYCLES): `FT_WR`=0; data held. At the end, choose the next step:
    - header byte 0 → header byte 1 (WAIT_TXE);
    - header byte 1 → FETCH addr 0;
    - low byte → high byte (WAIT_TXE);
    - high byte with addr < SAMPLING_NUM → addr+1, FETCH;
    - high byte with addr = SAMPLING_NUM → DONE.
  - DONE (1 cycle): `UPLOAD_DONE`=1, `FT_DATA_OE`=0 → IDLE.
- `FT_TXE_N` is only sampled in WAIT_TXE. If it rises during STROBE/GAP, the current byte still completes.
- An address compare against SAMPLING_NUM terminates the run; the counter never wraps.
- START during any non-IDLE state is ignored, with no queueing.
- RST mid-transfer: all state is abandoned next edge and the partial upload is not resumed.
- Reset values: `FT_WR`=0, `FT_DATA`=8'h00, `FT_DATA_OE`=0, `RAM_RD_ADDR`=0, `BUSY`=0, `UPLOAD_DONE`=0, state IDLE.

## Timing
- All outputs are registered.
- With `txe_s` continuously 0:
  - byte = 1 (WAIT) + 1 (SETUP) + WR_PULSE_CYCLES + WR_GAP_CYCLES = 7 cycles;
  - word = 2 + 2×7 = 16 cycles;
  - header = 14 cycles.
- START sampled at edge k → BUSY=1 at k+1. With defaults, UPLOAD_DONE is high during cycle k+1+14+16×1024 = k+16399.
- Data setup to the `FT_WR` rising edge is ≥1 cycle. Data hold after the falling edge is WR_GAP_CYCLES cycles.
- `FT_TXE_N` latency is 2 cycles (synchronizer) plus 1 (WAIT decision).
- RAM contract: address stable in FETCH cycle 1; data valid in cycle 2.

## Structure
- Shared package (`ft245_pkg`): state encoding constants, default SYNC_WORD, and FT245 timing defaults (WR_PULSE_CYCLES, WR_GAP_CYCLES), reused by the future FT245 read path.
- One sub-module: `sync_2ff` (generic 2-flop synchronizer, reset value parameter) for `FT_TXE_N`.

## Test plan
- Reset, TXE_N=0, RAM[a]=a: START → byte stream 5A,A5,00,00,01,00,…,FF,03; exactly 2050 FT_WR pulses; UPLOAD_DONE at k+16399.
- SEND_HEADER=0, SAMPLING_NUM=3, RAM={0x0ABC,0x0123,0x0FFF,0x0000} → bytes BC,0A,23,01,FF,0F,00,00; one UPLOAD_DONE.
- TXE_N held high 50 cycles before byte 3 → FT_WR stays 0 and the byte is unchanged; resumes 3 cycles after TXE_N falls; no byte lost or duplicated.
- TXE_N rises during STROBE → current pulse completes with full width; next byte waits for TXE_N low.
- START re-pulsed mid-upload → ignored; byte count and UPLOAD_DONE unchanged. RST asserted at byte 100 → next cycle FT_WR=0, FT_DATA_OE=0, BUSY=0, addr=0.
- Check every byte: FT_DATA stable from SETUP through GAP; FT_WR high exactly WR_PULSE_CYCLES cycles.
